// File: rtl/regbank_seq_ctrl.sv
// Fetch/decode/execute/write-back sequencer for the 16x8 register bank and ALU.
// Optional retired-instruction counter is enabled by defining REGBANK_SEQ_RETIRE_CNT_EN.
module regbank_seq_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned PC_W        = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_pc,
    input  logic            i_imem_ack,
    input  logic [15:0]     i_instr,
    output logic [3:0]      o_read_reg1,
    output logic [3:0]      o_read_reg2,
    output logic [3:0]      o_alu_op,
    output logic            o_write_en,
    output logic [3:0]      o_write_reg,
    output logic            o_busy,
    output logic            o_halted
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]     o_retired
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpJmp  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [3:0] opcode;
    assign opcode = ir_q[15:12];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StFetch;
            end
            StFetch: begin
                if (i_imem_ack) begin
                    ir_d    = i_instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (opcode)
                    OpHalt: state_d = StHalt;
                    OpJmp: begin
                        pc_d    = PC_W'(ir_q[7:0]);
                        state_d = StFetch;
                    end
                    OpNop: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = StFetch;
                    end
                    default: begin
                        // Counter reaching zero marks the last EXEC cycle.
                        cnt_d   = 4'(EXEC_CYCLES - 1);
                        state_d = StExec;
                    end
                endcase
            end
            StExec: begin
                if (cnt_q == 4'd0) state_d = StWb;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StWb: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = StFetch;
            end
            StHalt: begin
                if (i_start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only.
    always_comb begin
        o_imem_req  = (state_q == StFetch);
        o_pc        = pc_q;
        o_read_reg1 = 4'd0;
        o_read_reg2 = 4'd0;
        o_alu_op    = 4'd0;
        o_write_en  = 1'b0;
        o_write_reg = 4'd0;
        o_busy      = (state_q != StIdle) && (state_q != StHalt);
        o_halted    = (state_q == StHalt);
        if ((state_q == StDecode) || (state_q == StExec)) begin
            o_read_reg1 = ir_q[7:4];
            o_read_reg2 = ir_q[3:0];
        end
        if (state_q == StExec) o_alu_op = opcode;
        if (state_q == StWb) begin
            o_write_reg = ir_q[11:8];
            o_write_en  = (ir_q[11:8] != 4'd0);
        end
    end

`ifdef REGBANK_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;
    logic        retire;

    assign retire = (state_q == StWb) ||
                    ((state_q == StDecode) && ((opcode == OpNop) || (opcode == OpJmp)));

    always_comb begin
        retired_d = retired_q;
        if ((state_q == StHalt) && i_start) retired_d = 16'd0;
        else if (retire)                    retired_d = retired_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) retired_q <= 16'd0;
        else          retired_q <= retired_d;
    end

    assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_regbank_seq_ctrl.sv
// Self-checking bench for regbank_seq_ctrl: directed table, random instruction stream
// checked against an instruction-level model, and reset/halt corner sequences.
module tb_regbank_seq_ctrl;

    localparam int unsigned EXEC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        req, we, busy, halted;
    logic [7:0]  pc;
    logic [3:0]  rd1, rd2, alu, wr;
    logic [15:0] retired;

    regbank_seq_ctrl #(
        .EXEC_CYCLES(EXEC),
        .PC_W       (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .o_imem_req (req),
        .o_pc       (pc),
        .i_imem_ack (ack),
        .i_instr    (instr),
        .o_read_reg1(rd1),
        .o_read_reg2(rd2),
        .o_alu_op   (alu),
        .o_write_en (we),
        .o_write_reg(wr),
        .o_busy     (busy),
        .o_halted   (halted)
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        ,
        .o_retired  (retired)
`endif
    );

`ifndef REGBANK_SEQ_RETIRE_CNT_EN
    assign retired = 16'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          nwait;
        logic [3:0]  rd1;
        logic [3:0]  rd2;
        logic [3:0]  alu;
        int          alu_cycles;
        logic        we;
        logic [3:0]  wr;
        logic        halt;
        logic [7:0]  next_pc;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mpc = 8'd0;
    int unsigned mret = 0;
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level expectations straight from the opcode/field rules.
    function automatic vec_t model(input logic [15:0] ins, input int nw, input logic [7:0] cur_pc);
        vec_t v;
        v.instr      = ins;
        v.nwait      = nw;
        v.rd1        = ins[7:4];
        v.rd2        = ins[3:0];
        v.alu        = 4'd0;
        v.alu_cycles = 0;
        v.we         = 1'b0;
        v.wr         = 4'd0;
        v.halt       = (ins[15:12] == 4'hF);
        v.next_pc    = cur_pc;
        if (ins[15:12] == 4'hE) begin
            v.next_pc = ins[7:0];
        end else if (ins[15:12] == 4'h0) begin
            v.next_pc = 8'((int'(cur_pc) + 1) % 256);
        end else if (!v.halt) begin
            v.alu        = ins[15:12];
            v.alu_cycles = EXEC;
            v.wr         = ins[11:8];
            v.we         = (ins[11:8] != 4'd0);
            v.next_pc    = 8'((int'(cur_pc) + 1) % 256);
        end
        return v;
    endfunction

    // Entered one cycle into FETCH; leaves at the next FETCH cycle (or in HALT).
    task automatic run_instr(input vec_t v);
        for (int i = 0; i <= v.nwait; i++) begin
            chk("fetch_req", req, 1);
            chk("fetch_pc", pc, mpc);
            if (i == v.nwait) begin
                ack   = 1'b1;
                instr = v.instr;
            end else begin
                ack   = 1'b0;
                instr = 16'($urandom);
            end
            step();
        end
        ack   = 1'b0;
        instr = 16'($urandom);
        start = 1'($urandom_range(0, 1));
        chk("dec_req", req, 0);
        chk("dec_rd1", rd1, v.rd1);
        chk("dec_rd2", rd2, v.rd2);
        chk("dec_alu", alu, 0);
        chk("dec_busy", busy, 1);
        ack = 1'($urandom_range(0, 1));
        step();
        for (int i = 0; i < v.alu_cycles; i++) begin
            chk("exec_alu", alu, v.alu);
            chk("exec_rd1", rd1, v.rd1);
            chk("exec_rd2", rd2, v.rd2);
            chk("exec_we", we, 0);
            ack   = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            step();
        end
        if (v.alu_cycles > 0) begin
            chk("wb_we", we, v.we);
            chk("wb_reg", wr, v.wr);
            chk("wb_alu", alu, 0);
            step();
        end
        start = 1'b0;
        ack   = 1'b0;
        if (v.halt) begin
            chk("halt_halted", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_req", req, 0);
        end else begin
            mret++;
            chk("next_req", req, 1);
            chk("next_pc", pc, v.next_pc);
            chk("next_we", we, 0);
        end
        mpc = v.next_pc;
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        chk("retired", retired, 32'(mret[15:0]));
`endif
    endtask

    task automatic restart();
        start = 1'b1;
        step();
        start = 1'b0;
        mpc   = 8'd0;
        mret  = 0;
        chk("restart_req", req, 1);
        chk("restart_pc", pc, 0);
        chk("restart_halted", halted, 0);
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        chk("restart_retired", retired, 0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_rd"}, {rd1, rd2}, 0);
        chk({tag, "_alu"}, alu, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_wr"}, wr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    initial begin
        tbl[0] = '{16'h5312, 2, 4'h1, 4'h2, 4'h5, EXEC, 1'b1, 4'h3, 1'b0, 8'h01};
        tbl[1] = '{16'h7045, 0, 4'h4, 4'h5, 4'h7, EXEC, 1'b0, 4'h0, 1'b0, 8'h02};
        tbl[2] = '{16'h0000, 1, 4'h0, 4'h0, 4'h0, 0, 1'b0, 4'h0, 1'b0, 8'h03};
        tbl[3] = '{16'hE0FF, 0, 4'hF, 4'hF, 4'h0, 0, 1'b0, 4'h0, 1'b0, 8'hFF};
        tbl[4] = '{16'hE0A0, 0, 4'hA, 4'h0, 4'h0, 0, 1'b0, 4'h0, 1'b0, 8'hA0};
        tbl[5] = '{16'hE0FF, 3, 4'hF, 4'hF, 4'h0, 0, 1'b0, 4'h0, 1'b0, 8'hFF};
        tbl[6] = '{16'h1234, 0, 4'h3, 4'h4, 4'h1, EXEC, 1'b1, 4'h2, 1'b0, 8'h00};
        tbl[7] = '{16'hF000, 1, 4'h0, 4'h0, 4'h0, 0, 1'b0, 4'h0, 1'b1, 8'h00};

        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        ack   = 1'b1;
        step();
        step();
        ack = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_req", req, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        mpc   = 8'd0;
        mret  = 0;

        for (int i = 0; i < 8; i++) run_instr(tbl[i]);

        ack = 1'b1;
        step();
        step();
        ack = 1'b0;
        chk("halt_ack_halted", halted, 1);
        chk("halt_ack_req", req, 0);
        chk("halt_ack_busy", busy, 0);
        restart();

        run_instr(model(16'h0000, 1, mpc));
        run_instr(model(16'h6A21, 0, mpc));
        run_instr(model(16'hE010, 2, mpc));
        run_instr(model(16'hF123, 0, mpc));
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        chk("retired_seq", retired, 3);
`endif
        restart();

        for (int n = 0; n < 80; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            run_instr(model(ri, int'($urandom_range(0, 3)), mpc));
            if (ri[15:12] == 4'hF) restart();
        end

        // Reset in the second EXEC cycle of an ALU op must drop the pending write.
        ack   = 1'b1;
        instr = 16'h5312;
        step();
        ack = 1'b0;
        step();
        step();
        chk("pre_reset_alu", alu, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_reset_we", we, 0);
        end
        rst_n = 1'b1;
        step();
        step();
        chk_all_zero("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
